output_port_allocator: RTL and testbench
========================================

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 Parameter: NUM_PORTS, 5, number of requesting input ports; port index 0=Local, 1=North, 2=East, 3=South, 4=West.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, stall cycles before a forced lock release; used only when the timeout feature is compiled in.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: req  input  NUM_PORTS  per-input flit-valid request for this output port.
REQ-006 Port: tail  input  NUM_PORTS  per-input flag: the current flit is the packet tail.
REQ-007 Port: credit_avail  input  1  downstream buffer can accept one flit this cycle.
REQ-008 Port: grant  output  NUM_PORTS  registered one-hot grant; all zero when no lock is held.
REQ-009 Port: sel  output  3  registered binary index of the granted port, for the crossbar mux.
REQ-010 Port: fire  output  1  combinational transfer strobe: (grant & req) != 0 and credit_avail.
REQ-011 Port: busy  output  1  high while in LOCKED.
REQ-012 Port: timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-013 FSM states SHALL be: IDLE and LOCKED.
REQ-014 IDLE, any req set: select the winner round-robin, searching from last_served+1 upward and wrapping mod NUM_PORTS; at the next edge, register grant/sel and enter LOCKED (grant latency 1 cycle).
REQ-015 IDLE, req == 0: remain in IDLE with grant = 0.
REQ-016 LOCKED: grant SHALL hold, regardless of other requests, until the holder fires with tail set.
REQ-017 LOCKED, fire with the holder's tail = 1: at the next edge, clear grant, set last_served = holder, and enter IDLE; the next grant follows at the earliest one cycle later (one-cycle bubble between packets).
REQ-018 LOCKED, holder deasserts req or credit_avail = 0: fire = 0 and the lock is retained.
REQ-019 req/tail bits of non-granted ports SHALL be ignored.
REQ-020 Only the holder's tail bit SHALL be evaluated, and only when fire = 1.
REQ-021 The index arithmetic for the wrap SHALL be done modulo NUM_PORTS (4 -> 0), never modulo 8.
REQ-022 The same port SHALL be re-grantable only after every other requesting port has been served.

Reset
REQ-023 While rst is high, the block SHALL be in state IDLE with grant = 0, sel = 0, busy = 0, timeout = 0, last_served = 4 (West), and the stall counter = 0.
REQ-024 With last_served = 4 after reset, Local has highest priority on the first arbitration.
REQ-025 Reset asserted mid-packet SHALL drop the lock immediately (asynchronously); no tail is required.

Configuration
REQ-026 Macro ALLOC_TIMEOUT_EN: when defined, a stall counter of width $clog2(TIMEOUT_CYCLES) SHALL be implemented with the following behaviour:
- increments each LOCKED cycle with fire = 0;
- clears on fire and in IDLE;
- on reaching TIMEOUT_CYCLES-1, the block forces release as in REQ-017 (last_served = holder) and pulses timeout for 1 cycle.
REQ-027 Without ALLOC_TIMEOUT_EN: no counter is built, timeout SHALL be tied to 0, and the lock holds indefinitely.

Structure
REQ-028 Shared package noc_pkg SHALL hold:
- port index constants PORT_L/N/E/S/W;
- NUM_PORTS;
- the allocator state enum.
REQ-029 The combinational round-robin picker SHALL be a sub-module rr_priority_pick (inputs: req and last_served; outputs: one-hot winner, index, and any flag).

Verification
REQ-030 After reset, req = 5'b11111 -> grant = 00001 (Local) one cycle later.
REQ-031 Local holds the lock; fire a 3-flit packet (tail on the 3rd flit) with req = 11111 -> grant stays 00001 for the 3 fires, goes to 0 for 1 cycle, then becomes 00010 (North).
REQ-032 last_served = West, req = 10001 -> grant Local; next packet -> grant West; the next after that -> Local (wrap 4 -> 0).
REQ-033 Locked with credit_avail = 0 for 5 cycles -> fire = 0 and grant unchanged; when credit returns, fire = 1.
REQ-034 rst asserted between cycles mid-packet -> grant = 0 and busy = 0 immediately, without waiting for a clock edge; after release, req = 00100 -> grant 00100.
REQ-035 With ALLOC_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the holder stalls for 16 cycles -> timeout pulses once, grant clears, and the next requester is granted.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, port count, allocator state.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned SEL_W     = 3;

    localparam logic [SEL_W-1:0] PORT_L = 3'd0;
    localparam logic [SEL_W-1:0] PORT_N = 3'd1;
    localparam logic [SEL_W-1:0] PORT_E = 3'd2;
    localparam logic [SEL_W-1:0] PORT_S = 3'd3;
    localparam logic [SEL_W-1:0] PORT_W = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester after last_served_i,
// wrapping modulo NUM_PORTS.
//   req_i         : per-port requests
//   last_served_i : index of the most recently served port
//   winner_o      : one-hot winner (zero when no request)
//   idx_o         : binary index of the winner
//   any_o         : at least one request present
module rr_priority_pick
    import noc_pkg::*;
#(
    parameter int unsigned NUM_PORTS = noc_pkg::NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [SEL_W-1:0]     last_served_i,
    output logic [NUM_PORTS-1:0] winner_o,
    output logic [SEL_W-1:0]     idx_o,
    output logic                 any_o
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [31:0] cand;
    logic        found;

    // Scan last_served+1 .. last_served+NUM_PORTS; the last candidate is the
    // previous holder itself, so it only wins when nobody else asks.
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = (32'(last_served_i) + 32'(i)) % 32'(NUM_PORTS);
            if (!found && req_i[IDX_W'(cand)]) begin
                found                     = 1'b1;
                idx_o                     = SEL_W'(cand);
                winner_o[IDX_W'(cand)]    = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/output_port_allocator.sv
// Output-port allocator: locks one input onto this output for a whole packet,
// round-robin between packets.
//   clk, rst      : clock, asynchronous active-high reset
//   req, tail     : per-input flit valid / tail flag
//   credit_avail  : downstream can accept a flit this cycle
//   grant, sel    : registered one-hot grant and its binary index
//   fire          : combinational transfer strobe
//   busy          : lock held
//   timeout       : one-cycle pulse on a forced release
// Optional build macro ALLOC_TIMEOUT_EN adds a stall counter that forces a
// release after TIMEOUT_CYCLES stalled cycles; otherwise timeout is 0.
module output_port_allocator
    import noc_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = noc_pkg::NUM_PORTS,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 credit_avail,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_W-1:0]     sel,
    output logic                 fire,
    output logic                 busy,
    output logic                 timeout
);

    alloc_state_e         state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     last_q, last_d;

    logic [NUM_PORTS-1:0] pick_winner;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 holder_tail;
    logic                 force_rel;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i         (req),
        .last_served_i (last_q),
        .winner_o      (pick_winner),
        .idx_o         (pick_idx),
        .any_o         (pick_any)
    );

    // Only the holder's req/tail matter; grant is zero outside LOCKED.
    assign fire        = (|(grant_q & req)) & credit_avail;
    assign holder_tail = |(grant_q & tail);

    // State and grant registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the lock until tail fires or timeout
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_any) begin
                    grant_d = pick_winner;
                    sel_d   = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if ((fire && holder_tail) || force_rel) begin
                    grant_d = '0;
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q == ST_LOCKED);

`ifdef ALLOC_TIMEOUT_EN
    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_q;

    // Stall counter: counts LOCKED cycles without a transfer
    always_comb begin
        stall_d   = '0;
        force_rel = 1'b0;
        if (state_q == ST_LOCKED && !fire) begin
            if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                force_rel = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: directed scenarios plus
// random traffic compared against a packet-level reference model.
module tb_output_port_allocator;

    localparam int NP  = 5;
    localparam int TMO = 16;

    logic          clk;
    logic          rst;
    logic [NP-1:0] req;
    logic [NP-1:0] tail;
    logic          credit_avail;
    logic [NP-1:0] grant;
    logic [2:0]    sel;
    logic          fire;
    logic          busy;
    logic          timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: holder index (-1 = no lock), last served, stall count
    int m_holder;
    int m_last;
    int m_stall;
    bit m_tmo;
    int n_tmo;

    output_port_allocator #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .tail         (tail),
        .credit_avail (credit_avail),
        .grant        (grant),
        .sel          (sel),
        .fire         (fire),
        .busy         (busy),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_last   = 4;
        m_stall  = 0;
        m_tmo    = 1'b0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic cycle(input logic [NP-1:0] r, input logic [NP-1:0] t, input logic c);
        logic [NP-1:0] eg;
        logic          ef;
        bit            found;
        int            p;
        req          = r;
        tail         = t;
        credit_avail = c;
        eg = '0;
        ef = 1'b0;
        if (m_holder >= 0) begin
            eg[3'(m_holder)] = 1'b1;
            ef = r[3'(m_holder)] && c;
        end
        @(negedge clk);
        check("grant", 32'(grant), 32'(eg));
        check("fire", 32'(fire), 32'(ef));
        check("busy", 32'(busy), 32'(m_holder >= 0));
        check("timeout", 32'(timeout), 32'(m_tmo));
        if (m_holder >= 0) check("sel", 32'(sel), 32'(m_holder));
        if (timeout === 1'b1) n_tmo++;
        @(posedge clk);
        m_tmo = 1'b0;
        if (m_holder < 0) begin
            m_stall = 0;
            found   = 1'b0;
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (!found && r[3'(p)]) begin
                    found    = 1'b1;
                    m_holder = p;
                end
            end
        end else if (ef) begin
            m_stall = 0;
            if (t[3'(m_holder)]) begin
                m_last   = m_holder;
                m_holder = -1;
            end
        end else begin
`ifdef ALLOC_TIMEOUT_EN
            if (m_stall == TMO - 1) begin
                m_last   = m_holder;
                m_holder = -1;
                m_tmo    = 1'b1;
                m_stall  = 0;
            end else begin
                m_stall++;
            end
`endif
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] rr;
        logic [NP-1:0] tt;
        logic          cc;

        rst          = 1'b1;
        req          = '0;
        tail         = '0;
        credit_avail = 1'b0;
        n_tmo        = 0;
        model_reset();
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_fire", 32'(fire), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset all request: Local first, 3-flit packet, bubble, then North
        cycle(5'b11111, 5'b00000, 1'b1);
        check("first_grant_local", 32'(grant), 32'h01);
        cycle(5'b11111, 5'b11110, 1'b1);
        cycle(5'b11111, 5'b11110, 1'b1);
        cycle(5'b11111, 5'b00001, 1'b1);
        check("bubble_grant", 32'(grant), 32'h00);
        check("bubble_busy", 32'(busy), 32'd0);
        cycle(5'b11111, 5'b00000, 1'b1);
        check("next_grant_north", 32'(grant), 32'h02);

        // Credit stall for 5 cycles holds the lock, then credit returns
        for (int i = 0; i < 5; i++) cycle(5'b11111, 5'b11111, 1'b0);
        check("stall_grant_held", 32'(grant), 32'h02);
        cycle(5'b11111, 5'b00010, 1'b1);

        // Wrap 4 -> 0 with only Local and West requesting
        do_reset();
        cycle(5'b10001, 5'b00000, 1'b1);
        check("wrap_local", 32'(grant), 32'h01);
        cycle(5'b10001, 5'b10001, 1'b1);
        cycle(5'b10001, 5'b00000, 1'b1);
        check("wrap_west", 32'(grant), 32'h10);
        check("wrap_west_sel", 32'(sel), 32'd4);
        cycle(5'b10001, 5'b10001, 1'b1);
        cycle(5'b10001, 5'b00000, 1'b1);
        check("wrap_back_local", 32'(grant), 32'h01);

        // Asynchronous reset mid-packet, then East alone
        cycle(5'b00001, 5'b00000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'h00);
        check("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(5'b00100, 5'b00000, 1'b1);
        check("east_after_rst", 32'(grant), 32'h04);
        cycle(5'b00100, 5'b00100, 1'b1);

`ifdef ALLOC_TIMEOUT_EN
        // Holder stalls 16 cycles: forced release, single timeout pulse
        do_reset();
        n_tmo = 0;
        cycle(5'b00010, 5'b00000, 1'b1);
        check("tmo_lock_north", 32'(grant), 32'h02);
        for (int i = 0; i < TMO; i++) cycle(5'b00011, 5'b00000, 1'b0);
        check("tmo_pulse", 32'(timeout), 32'd1);
        check("tmo_grant_clear", 32'(grant), 32'h00);
        cycle(5'b00011, 5'b00000, 1'b1);
        check("tmo_next_local", 32'(grant), 32'h01);
        cycle(5'b00011, 5'b00001, 1'b1);
        check("tmo_pulse_count", 32'(n_tmo), 32'd1);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rr = NP'($urandom_range(0, 31));
            tt = '0;
            for (int b = 0; b < NP; b++) tt[b] = ($urandom_range(0, 2) == 0);
            cc = ($urandom_range(0, 3) != 0);
            cycle(rr, tt, cc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
